// File: rtl/simd_shift_seq.sv
// simd_shift_seq: multi-bit shift sequencer for the 1-bit SIMD lane shifter.
// It accepts an operand, a shift distance, a lane mode and a direction. It then
// iterates the external single-position shifter once per clock and presents the
// result over a valid/ready handshake.
module simd_shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] sh_in,
  output logic             sh_H,
  output logic             sh_O,
  output logic             sh_Q,
  output logic             sh_left,
  input  logic [WIDTH-1:0] sh_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] data;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       mode;
  logic             left;
  logic             ready_q;
  logic [AMT_W-1:0] lane_w;
  logic [AMT_W-1:0] k;
  logic             accept;

  // ready_q is high only in IDLE, and never in the first cycle after reset.
  // This lets an accepted request imply the IDLE state.
  assign accept = in_valid & ready_q;

  // Lane width from the requested mode, and the saturated shift count
  always_comb begin
    lane_w = AMT_W'(16);
    case (in_mode)
      2'b00:   lane_w = AMT_W'(4);
      2'b01:   lane_w = AMT_W'(8);
      default: lane_w = AMT_W'(16);
    endcase
    k = (in_amt >= lane_w) ? lane_w : in_amt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (k == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt <= AMT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand register and request latches.
  // in_ready is registered from the next state, so it has no path from any input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      cnt     <= '0;
      mode    <= 2'b00;
      left    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        data <= in_data;
        cnt  <= k;
        mode <= in_mode;
        left <= in_left;
      end else if (state == SHIFT) begin
        data <= sh_out;
        cnt  <= cnt - AMT_W'(1);
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state == DONE);
  assign out_data  = data;
  assign sh_in     = data;
  assign sh_H      = mode[1];
  assign sh_O      = (mode == 2'b01);
  assign sh_Q      = (mode == 2'b00);
  assign sh_left   = left;

endmodule

// File: tb/tb_simd_shift_seq.sv
// Directed bench for simd_shift_seq. It includes a behavioural model of the
// 1-bit lane shifter so that the sequencer is exercised in closed loop.
module tb_simd_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_mode;
  logic        in_left;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] sh_in;
  logic        sh_H, sh_O, sh_Q, sh_left;
  logic [15:0] sh_out;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  simd_shift_seq #(.WIDTH(16), .AMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_left(in_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sh_in(sh_in), .sh_H(sh_H), .sh_O(sh_O), .sh_Q(sh_Q), .sh_left(sh_left),
    .sh_out(sh_out)
  );

  always #5 clk = ~clk;

  // Shifter model: one-position logical shift inside each lane
  always_comb begin
    logic [3:0] nib;
    logic [7:0] byt;
    sh_out = '0;
    nib = '0;
    byt = '0;
    if (sh_Q) begin
      for (int i = 0; i < 4; i++) begin
        nib = sh_in[4*i +: 4];
        sh_out[4*i +: 4] = sh_left ? {nib[2:0], 1'b0} : {1'b0, nib[3:1]};
      end
    end else if (sh_O) begin
      for (int i = 0; i < 2; i++) begin
        byt = sh_in[8*i +: 8];
        sh_out[8*i +: 8] = sh_left ? {byt[6:0], 1'b0} : {1'b0, byt[7:1]};
      end
    end else begin
      sh_out = sh_left ? {sh_in[14:0], 1'b0} : {1'b0, sh_in[15:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present a request and let it be accepted at the next edge; return 1 ns after it
  task automatic start_job(input string tag, input logic [15:0] d, input logic [4:0] a,
                           input logic [1:0] m, input logic l);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_data = d; in_amt = a; in_mode = m; in_left = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles after acceptance until out_valid (bounded), then check latency and data
  task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_data);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, out_data, exp_data);
  endtask

  // Consume the result; check the hand-back to IDLE in the next cycle
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovalid_fall"}, out_valid, 0);
    chk({tag, "_iready_rise"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
    in_left = 1'b0; out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    in_data = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sel", {sh_H, sh_O, sh_Q}, 3'b001);
    chk("rst_sh_left", sh_left, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // Mode 10, left 3: 0x0001 -> 0x0008, out_valid in cycle 4
    start_job("m10l3", 16'h0001, 5'd3, 2'b10, 1'b1);
    chk("m10l3_sel", {sh_H, sh_O, sh_Q}, 3'b100);
    chk("m10l3_busy_ready", in_ready, 0);
    chk("m10l3_busy_valid", out_valid, 0);
    wait_done("m10l3", 4, 16'h0008);
    chk("m10l3_sel_done", {sh_H, sh_O, sh_Q}, 3'b100);
    consume("m10l3");

    // Mode 00, right 1: 0xFFFF -> 0x7777 in cycle 2
    start_job("m00r1", 16'hFFFF, 5'd1, 2'b00, 1'b0);
    chk("m00r1_sel", {sh_H, sh_O, sh_Q}, 3'b001);
    wait_done("m00r1", 2, 16'h7777);
    consume("m00r1");

    // Mode 01, left 4: 0x1234 -> 0x2040 in cycle 5
    start_job("m01l4", 16'h1234, 5'd4, 2'b01, 1'b1);
    chk("m01l4_sel", {sh_H, sh_O, sh_Q}, 3'b010);
    chk("m01l4_left", sh_left, 1);
    wait_done("m01l4", 5, 16'h2040);
    consume("m01l4");

    // Saturation: mode 00, amount 9 -> 4 shift cycles
    start_job("sat00", 16'hFFFF, 5'd9, 2'b00, 1'b1);
    wait_done("sat00", 5, 16'h0000);
    consume("sat00");

    // Saturation: mode 10, amount 31 -> 16 shift cycles
    start_job("sat10", 16'hFFFF, 5'd31, 2'b10, 1'b0);
    wait_done("sat10", 17, 16'h0000);
    consume("sat10");

    // Boundary: mode 01, amount exactly 8
    start_job("k8", 16'hFFFF, 5'd8, 2'b01, 1'b0);
    wait_done("k8", 9, 16'h0000);
    consume("k8");

    // Mode 10 right 15: 0x8000 -> 0x0001
    start_job("m10r15", 16'h8000, 5'd15, 2'b10, 1'b0);
    wait_done("m10r15", 16, 16'h0001);
    consume("m10r15");

    // Zero amount: data passes through in cycle 1
    start_job("zero", 16'hA5A5, 5'd0, 2'b00, 1'b1);
    wait_done("zero", 1, 16'hA5A5);
    consume("zero");

    // Backpressure with ignored in_valid pulses, then immediate re-accept
    start_job("bp", 16'h00F0, 5'd2, 2'b10, 1'b1);
    wait_done("bp", 3, 16'h03C0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h1111 * (i + 1); in_amt = 5'd0;
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'h03C0);
      chk("bp_hold_ready", in_ready, 0);
    end
    in_data = 16'h0F0F; in_amt = 5'd1; in_mode = 2'b01; in_left = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_ovalid_fall", out_valid, 0);
    chk("bp_iready_rise", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_reaccept_busy", in_ready, 0);
    wait_done("bp_next", 2, 16'h0707);
    consume("bp_next");

    // Reset in the second SHIFT cycle of a k=8 job
    start_job("rmid", 16'hFFFF, 5'd8, 2'b01, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rmid_out_valid", out_valid, 0);
    chk("rmid_out_data", out_data, 16'h0000);
    chk("rmid_in_ready", in_ready, 0);
    chk("rmid_sel", {sh_H, sh_O, sh_Q}, 3'b001);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rmid_rel_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("rmid_no_pulse", out_valid, 0);

    // Mode 11 behaves as mode 10
    start_job("m11", 16'h0001, 5'd3, 2'b11, 1'b1);
    chk("m11_sel", {sh_H, sh_O, sh_Q}, 3'b100);
    wait_done("m11", 4, 16'h0008);
    consume("m11");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/simd_shift_seq.md
# simd_shift_seq

Multi-bit shift sequencer for the 1-bit SIMD lane shifter. It accepts a 16-bit operand, a shift amount, a lane mode and a direction over a valid/ready handshake. It then iterates the single-position shifter once per clock until the requested distance is reached, and returns the result over a second valid/ready handshake. It sits between the SIMD issue logic and the shifter datapath: it owns the operand register and drives the shifter's lane-select and direction inputs.

## Interface
Parameters:
- `WIDTH`, 16: operand width. Fixed at 16 to match the shifter.
- `AMT_W`, 5: shift-amount width, covering the range 0..31.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_data`  in  16  operand.
- `in_amt`  in  5  shift distance.
- `in_mode`  in  2  lane mode: 00 = four 4-bit lanes, 01 = two 8-bit lanes, 10 = one 16-bit lane, 11 = reserved (treated as 10).
- `in_left`  in  1  1 = left shift, 0 = logical right shift.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  16  shifted result.
- `sh_in`  out  16  operand to the shifter (the working register).
- `sh_H`, `sh_O`, `sh_Q`  out  1 each  one-hot lane select, decoded from the latched mode.
- `sh_left`  out  1  latched direction.
- `sh_out`  in  16  shifter result, combinational from `sh_in`.

## Operation
- Registers:
  - `data` (16 bits)
  - `cnt` (5 bits)
  - `mode` (2 bits)
  - `left` (1 bit)
  - `state` ∈ {IDLE, SHIFT, DONE}
- Lane width `LW`: 4 for mode 00, 8 for mode 01, 16 for modes 10 and 11.
- Effective count `k = min(in_amt, LW)`. Any amount ≥ LW zeroes every lane; the count saturates so the block never spends more than LW cycles shifting.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `data` ← `in_data`, `mode`, `left`, and `cnt` ← k.
  - Next state is DONE if k = 0, otherwise SHIFT.
- SHIFT:
  - Each cycle: `data` ← `sh_out`, `cnt` ← `cnt` − 1.
  - When `cnt` = 1, the next state is DONE.
  - `in_ready` = 0 and `out_valid` = 0.
- DONE:
  - `out_valid` = 1 and `out_data` = `data`.
  - On `out_ready`, the next state is IDLE.
  - `in_ready` = 0; there is no same-cycle hand-over to a new request.
- `sh_in` = `data` at all times.
- Lane-select decode:
  - `sh_H` = mode ∈ {10, 11}
  - `sh_O` = mode = 01
  - `sh_Q` = mode = 00
  - Exactly one of the three is high in every state, including after reset.
- Lane boundaries are enforced by the shifter. The sequencer never masks `data` itself.
- Inputs are sampled only on acceptance. Changes to `in_*` while the block is busy are ignored.

## Timing
- Reset (`rst` high at an edge):
  - state = IDLE, `data` = 0, `cnt` = 0, `mode` = 00, `left` = 0.
  - Outputs: `out_valid` = 0, `out_data` = 0x0000, `sh_Q` = 1, `sh_H` = 0, `sh_O` = 0, `sh_left` = 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after it is released.
- Reset mid-SHIFT or mid-DONE aborts the operation. There is no output pulse and the pending result is lost.
- Latency, with acceptance at edge 0:
  - k ≥ 1: SHIFT spans cycles 1..k and `out_valid` rises in cycle k+1.
  - k = 0: `out_valid` rises in cycle 1.
- Throughput: one request per k+2 cycles when `out_ready` is held high.
- Backpressure: `out_valid` and `out_data` stay stable until `out_ready` is seen. `out_valid` falls in the cycle after the handshake, and `in_ready` rises in that same cycle.
- All outputs are driven from registers or state-only decode. `in_ready` has no combinational path from any input.

## Test plan
- Mode 10, left, `in_amt`=3, `in_data`=0x0001 → `out_data`=0x0008; `out_valid` in cycle 4 after acceptance; `sh_H`=1 throughout.
- Mode 00, right, `in_amt`=1, `in_data`=0xFFFF → 0x7777 in cycle 2. Mode 01, left, `in_amt`=4, `in_data`=0x1234 → 0x2040 in cycle 5.
- Saturation: mode 00, `in_amt`=9, `in_data`=0xFFFF → 0x0000 with exactly 4 SHIFT cycles, `out_valid` in cycle 5. Mode 10, `in_amt`=31 → 16 SHIFT cycles.
- Zero amount: `in_amt`=0, `in_data`=0xA5A5 → `out_data`=0xA5A5 in cycle 1, with `sh_out` never sampled.
- Backpressure: hold `out_ready`=0 for 3 cycles. `out_data` stays stable and `in_ready`=0, and `in_valid` pulses during this period are ignored. After `out_ready`, a new request is accepted exactly one cycle later.
- Reset mid-operation: assert `rst` in the second SHIFT cycle of a k=8 job → the next cycle shows IDLE, `out_valid`=0, `out_data`=0x0000; `in_ready`=1 after `rst` is released. Mode 11 → `sh_H`=1 with behaviour identical to mode 10.
